// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state encoding and default sizing for the UART command controller
package uart_cmd_pkg;
  typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, CHK, HOLD} state_t;
  localparam logic [7:0] HDR_DEF = 8'hAA;
  localparam int MAX_LEN_DEF = 8;
  localparam int BUF_DEPTH = 8;
  localparam int BUF_AW = $clog2(BUF_DEPTH);
endpackage

// File: rtl/uart_cmd_buf.sv
// uart_cmd_buf: payload register file, one write port and one asynchronous read port
module uart_cmd_buf
  import uart_cmd_pkg::*;
(
  input  logic              BPS_CLK,
  input  logic              RSTn,
  input  logic              we,
  input  logic [BUF_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [BUF_AW-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [BUF_DEPTH];
  always_ff @(posedge BPS_CLK or negedge RSTn)
    if (!RSTn) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses HDR/CMD/LEN/payload/CHK frames from a byte receiver and holds the checked command
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] HDR     = HDR_DEF,
  parameter int         MAX_LEN = MAX_LEN_DEF,
  parameter int         TIMEOUT = 40
) (
  input  logic              BPS_CLK,
  input  logic              RSTn,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              rx_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_code,
  output logic [3:0]        cmd_len,
  input  logic [BUF_AW-1:0] pl_addr,
  output logic [7:0]        pl_data,
  output logic              err_chk,
  output logic              err_len,
  output logic              err_tmo,
  output logic              busy
);
  localparam int GW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [GW-1:0] gap;
  logic [BUF_AW-1:0] idx;
  logic [7:0] xr;
  logic act, tmo, len_bad, chk_bad, wr;
  // rx_done on the timeout cycle wins, so tmo requires the byte to be absent
  always_comb begin
    act = state inside {CMD, LEN, DATA, CHK};
    tmo = act && !rx_done && gap == GW'(TIMEOUT - 1);
    len_bad = state == LEN && rx_done && rx_data > 8'(MAX_LEN);
    chk_bad = state == CHK && rx_done && rx_data != xr;
    wr = state == DATA && rx_done;
    state_n = state;
    if (tmo || len_bad || chk_bad) state_n = IDLE;
    else if (state == HOLD) state_n = cmd_ready ? IDLE : HOLD;
    else if (rx_done)
      case (state)
        IDLE:    state_n = rx_data == HDR ? CMD : IDLE;
        CMD:     state_n = LEN;
        LEN:     state_n = rx_data == 8'd0 ? CHK : DATA;
        DATA:    state_n = {1'b0, idx} == cmd_len - 4'd1 ? CHK : DATA;
        CHK:     state_n = HOLD;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge BPS_CLK or negedge RSTn)
    if (!RSTn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge BPS_CLK or negedge RSTn)
    if (!RSTn) begin
      gap <= '0;
      idx <= '0;
      xr <= '0;
      cmd_code <= '0;
      cmd_len <= '0;
      err_chk <= 1'b0;
      err_len <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      gap <= (!act || rx_done) ? '0 : (&gap ? gap : gap + 1'b1);
      err_chk <= chk_bad;
      err_len <= len_bad;
      err_tmo <= tmo;
      if (rx_done && state == CMD) begin
        cmd_code <= rx_data;
        xr <= rx_data;
      end
      if (rx_done && state == LEN) begin
        cmd_len <= rx_data[3:0];
        xr <= xr ^ rx_data;
        idx <= '0;
      end
      if (wr) begin
        xr <= xr ^ rx_data;
        idx <= idx + 1'b1;
      end
    end
  uart_cmd_buf u_buf (
    .BPS_CLK(BPS_CLK),
    .RSTn(RSTn),
    .we(wr),
    .waddr(idx),
    .wdata(rx_data),
    .raddr(pl_addr),
    .rdata(pl_data)
  );
  assign cmd_valid = state == HOLD;
  assign rx_en = state != HOLD;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  logic BPS_CLK = 1'b0;
  logic RSTn, rx_done, rx_en, cmd_valid, cmd_ready, err_chk, err_len, err_tmo, busy;
  logic [7:0] rx_data, cmd_code, pl_data;
  logic [3:0] cmd_len;
  logic [2:0] pl_addr;
  int checks = 0;
  int errors = 0;
  logic held;
  always #5 BPS_CLK = ~BPS_CLK;
  uart_cmd_ctrl dut (
    .BPS_CLK(BPS_CLK),
    .RSTn(RSTn),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .rx_en(rx_en),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_code(cmd_code),
    .cmd_len(cmd_len),
    .pl_addr(pl_addr),
    .pl_data(pl_data),
    .err_chk(err_chk),
    .err_len(err_len),
    .err_tmo(err_tmo),
    .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge BPS_CLK);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask
  task automatic accept();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask
  task automatic pl(input string tag, input logic [2:0] a, input logic [7:0] exp);
    pl_addr = a;
    #1;
    check(tag, {24'd0, pl_data}, {24'd0, exp});
  endtask
  initial begin
    RSTn = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    cmd_ready = 1'b0;
    pl_addr = 3'd0;
    #3;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rx_en", {31'd0, rx_en}, 1);
    check("rst_valid", {31'd0, cmd_valid}, 0);
    check("rst_code", {24'd0, cmd_code}, 0);
    check("rst_len", {28'd0, cmd_len}, 0);
    check("rst_errs", {29'd0, err_chk, err_len, err_tmo}, 0);
    check("rst_pl", {24'd0, pl_data}, 0);
    #9 RSTn = 1'b1;
    tick();
    // basic two-byte payload frame
    send(8'hAA); send(8'h10); send(8'h02); send(8'h33); send(8'h44);
    check("f1_pre_valid", {31'd0, cmd_valid}, 0);
    send(8'h65);
    check("f1_valid", {31'd0, cmd_valid}, 1);
    check("f1_code", {24'd0, cmd_code}, 32'h10);
    check("f1_len", {28'd0, cmd_len}, 2);
    check("f1_rx_en", {31'd0, rx_en}, 0);
    pl("f1_pl0", 3'd0, 8'h33);
    pl("f1_pl1", 3'd1, 8'h44);
    accept();
    check("f1_done_valid", {31'd0, cmd_valid}, 0);
    check("f1_done_busy", {31'd0, busy}, 0);
    // zero-length frame, then bad checksum
    send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
    check("f2_valid", {31'd0, cmd_valid}, 1);
    check("f2_len", {28'd0, cmd_len}, 0);
    check("f2_code", {24'd0, cmd_code}, 32'h05);
    accept();
    send(8'hAA); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h66);
    check("f3_err_chk", {29'd0, err_chk, err_len, err_tmo}, 3'b100);
    check("f3_valid", {31'd0, cmd_valid}, 0);
    check("f3_busy", {31'd0, busy}, 0);
    tick();
    check("f3_chk_pulse", {31'd0, err_chk}, 0);
    // oversize length
    send(8'hAA); send(8'h10); send(8'h09);
    check("f4_err_len", {29'd0, err_chk, err_len, err_tmo}, 3'b010);
    check("f4_busy", {31'd0, busy}, 0);
    tick();
    check("f4_len_pulse", {31'd0, err_len}, 0);
    send(8'hAA); send(8'h07); send(8'h01); send(8'h5A); send(8'h5C);
    check("f5_valid", {31'd0, cmd_valid}, 1);
    check("f5_code", {24'd0, cmd_code}, 32'h07);
    pl("f5_pl0", 3'd0, 8'h5A);
    accept();
    // inter-byte timeout after CMD
    send(8'hAA); send(8'h10);
    repeat (39) tick();
    check("t1_no_tmo_yet", {31'd0, err_tmo}, 0);
    check("t1_busy_yet", {31'd0, busy}, 1);
    tick();
    check("t1_err_tmo", {29'd0, err_chk, err_len, err_tmo}, 3'b001);
    check("t1_busy", {31'd0, busy}, 0);
    tick();
    check("t1_tmo_pulse", {31'd0, err_tmo}, 0);
    // byte arriving exactly on the timeout cycle
    send(8'hAA); send(8'h10);
    repeat (39) tick();
    send(8'h00);
    check("t2_no_tmo", {31'd0, err_tmo}, 0);
    check("t2_busy", {31'd0, busy}, 1);
    send(8'h10);
    check("t2_valid", {31'd0, cmd_valid}, 1);
    accept();
    // back-pressure in HOLD with an injected byte
    send(8'hAA); send(8'h22); send(8'h01); send(8'h7E); send(8'h5D);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_data = 8'hAA;
      rx_done = (i == 5 || i == 6);
      tick();
      held = held & cmd_valid & ~rx_en;
    end
    rx_done = 1'b0;
    check("h_held", {31'd0, held}, 1);
    check("h_code", {24'd0, cmd_code}, 32'h22);
    check("h_len", {28'd0, cmd_len}, 1);
    pl("h_pl0", 3'd0, 8'h7E);
    accept();
    check("h_valid_drop", {31'd0, cmd_valid}, 0);
    check("h_rx_en", {31'd0, rx_en}, 1);
    check("h_busy", {31'd0, busy}, 0);
    // asynchronous reset during payload byte 1
    send(8'hAA); send(8'h33); send(8'h04); send(8'h11);
    rx_data = 8'h22;
    rx_done = 1'b1;
    #2 RSTn = 1'b0;
    #1;
    check("r_busy", {31'd0, busy}, 0);
    check("r_rx_en", {31'd0, rx_en}, 1);
    check("r_code", {24'd0, cmd_code}, 0);
    check("r_len", {28'd0, cmd_len}, 0);
    pl("r_pl0", 3'd0, 8'h00);
    rx_done = 1'b0;
    #2 RSTn = 1'b1;
    tick();
    send(8'hAA); send(8'h44); send(8'h02); send(8'h01); send(8'h02); send(8'h45);
    check("r2_valid", {31'd0, cmd_valid}, 1);
    check("r2_code", {24'd0, cmd_code}, 32'h44);
    check("r2_len", {28'd0, cmd_len}, 2);
    pl("r2_pl0", 3'd0, 8'h01);
    pl("r2_pl1", 3'd1, 8'h02);
    accept();
    check("r2_done", {31'd0, cmd_valid}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter HDR, default 8'hAA, meaning the frame start byte.
REQ-002 The block SHALL have parameter MAX_LEN, default 8, meaning the maximum payload byte count (range 1..8).
REQ-003 The block SHALL have parameter TIMEOUT, default 40, meaning the maximum inter-byte gap in BPS_CLK cycles.
REQ-004 The block SHALL have port BPS_CLK  in  1  clock, with all logic on its rising edge.
REQ-005 The block SHALL have port RSTn  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port rx_done  in  1  one-cycle strobe from the byte receiver, qualifying rx_data.
REQ-007 The block SHALL have port rx_data  in  8  received byte.
REQ-008 The block SHALL have port rx_en  out  1  enable to the byte receiver.
REQ-009 The block SHALL have port cmd_valid  out  1  complete, checked command available.
REQ-010 The block SHALL have port cmd_ready  in  1  consumer accepts the command.
REQ-011 The block SHALL have port cmd_code  out  8  command byte.
REQ-012 The block SHALL have port cmd_len  out  4  payload length.
REQ-013 The block SHALL have port pl_addr  in  3  payload read index.
REQ-014 The block SHALL have port pl_data  out  8  payload byte at pl_addr, combinational read.
REQ-015 The block SHALL have ports err_chk, err_len, err_tmo  out  1 each  one-cycle error pulses.
REQ-016 The block SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The frame format SHALL be HDR, CMD, LEN, LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-018 The FSM states SHALL be IDLE, CMD, LEN, DATA, CHK and HOLD, and the FSM SHALL advance only on a cycle with rx_done=1, except for timeout and HOLD exit.
REQ-019 In IDLE, rx_done with rx_data==HDR SHALL go to CMD, and any other byte SHALL be ignored.
REQ-020 In CMD, the byte SHALL be latched to cmd_code, the running XOR SHALL be set to the byte, and the FSM SHALL go to LEN.
REQ-021 In LEN, LEN>MAX_LEN SHALL pulse err_len and return to IDLE, LEN==0 SHALL go to CHK, and otherwise the FSM SHALL go to DATA; in every case cmd_len is latched and LEN is XORed into the running XOR.
REQ-022 In DATA, each byte SHALL be written to buffer[index] and XORed into the running XOR, with index starting at 0 and incrementing; after byte index==cmd_len-1 the FSM SHALL go to CHK.
REQ-023 In CHK, a match SHALL go to HOLD, and a mismatch SHALL pulse err_chk and go to IDLE.
REQ-024 cmd_valid SHALL be 1 exactly while in HOLD, first asserting the cycle after the CHK byte's rx_done (latency 1).
REQ-025 In HOLD, cmd_code, cmd_len and the buffer SHALL stay stable, and cmd_valid&cmd_ready SHALL return the FSM to IDLE on that edge, so cmd_valid=0 the next cycle.
REQ-026 rx_en SHALL be 0 in HOLD and 1 otherwise; rx_done seen in HOLD SHALL be ignored.
REQ-027 The gap counter SHALL clear on rx_done and in IDLE/HOLD, and otherwise increment, saturating.
REQ-028 In CMD, LEN, DATA or CHK, the counter reaching TIMEOUT-1 without rx_done SHALL pulse err_tmo and go to IDLE.
REQ-029 When rx_done coincides with the timeout cycle, the byte SHALL be processed and no timeout SHALL occur.
REQ-030 Error pulses SHALL be registered, asserted one cycle following the offending edge, and mutually exclusive.
REQ-031 pl_addr>=cmd_len SHALL return stale buffer contents, which are don't-care.

Reset
REQ-032 Asserting RSTn low at any time, including mid-frame or in HOLD, SHALL force IDLE immediately, with cmd_valid=0, cmd_code=0, cmd_len=0, error pulses=0, busy=0, rx_en=1, gap counter=0, index=0 and XOR=0.
REQ-033 Buffer contents after reset SHALL be 0.
REQ-034 After RSTn deasserts, the first accepted edge SHALL behave as IDLE.

Structure
REQ-035 Package uart_cmd_pkg SHALL hold the state encoding, the HDR default, the MAX_LEN default and the buffer depth constant.
REQ-036 Sub-module uart_cmd_buf SHALL implement the 8x8 payload register file with one write port and an asynchronous read port.
REQ-037 The FSM, XOR, gap counter and index SHALL reside in uart_cmd_ctrl.

Verification
REQ-038 The bench SHALL drive AA 10 02 33 44 65 -> cmd_valid=1 one cycle after the last rx_done, cmd_code=10, cmd_len=2, pl_data[0]=33, pl_data[1]=44.
REQ-039 The bench SHALL drive AA 05 00 05 -> cmd_valid, cmd_len=0; then AA 10 02 33 44 66 -> single err_chk pulse, no cmd_valid, busy=0 afterwards.
REQ-040 The bench SHALL drive AA 10 09 -> err_len pulse after LEN byte, IDLE; subsequent valid frame accepted.
REQ-041 The bench SHALL drive AA 10, then no rx_done for 40 cycles -> err_tmo at count 39, IDLE; also rx_done exactly at count 39 -> no err_tmo.
REQ-042 The bench SHALL hold cmd_ready=0 for 20 cycles after a valid frame -> cmd_valid held, rx_en=0, fields stable, injected rx_done ignored; then cmd_ready=1 for one cycle -> cmd_valid=0 next cycle, rx_en=1.
REQ-043 The bench SHALL assert RSTn low during DATA byte 1 of a len-4 frame -> all outputs at reset values asynchronously; the next valid frame decodes correctly.
